// File: rtl/fram_arb_pkg.sv
// Shared types and constants for the two-port FRAM arbiter.
// Holds the bus widths, port count, FSM encoding and pending-slot layout.
package fram_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef struct packed {
        logic              pend;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slot_t;

endpackage

// File: rtl/fram_rr_grant.sv
// Two-way round-robin grant: a lone requester always wins,
// a tie goes to the port that was not granted last.
module fram_rr_grant
    import fram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] pending,
    input  logic                 last,
    output logic [NUM_PORTS-1:0] grant
);

    always_comb begin
        grant = '0;
        case (pending)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/fram_arbiter.sv
// Two-port arbiter in front of a single FRAM controller.
// Each port owns one pending slot; a registered FSM issues one command at a time.
module fram_arbiter
    import fram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_read_en,
    input  logic              p0_write_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_read_en,
    input  logic              p1_write_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_req_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    slot_t                slot    [NUM_PORTS];
    logic [DATA_W-1:0]    rdata_q [NUM_PORTS];
    logic [ADDR_W-1:0]    addr_in [NUM_PORTS];
    logic [DATA_W-1:0]    wdat_in [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_en;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] grant;
    logic [1:0]           state;
    logic                 last;
    logic                 gidx;
    logic                 gsel;
    logic                 issue;
    logic                 done;

    assign rd_en      = {p1_read_en, p0_read_en};
    assign wr_en      = {p1_write_en, p0_write_en};
    assign addr_in[0] = p0_addr;
    assign addr_in[1] = p1_addr;
    assign wdat_in[0] = p0_wdata;
    assign wdat_in[1] = p1_wdata;

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pending[i] = slot[i].pend;
        end
    end

    fram_rr_grant u_grant (
        .pending (pending),
        .last    (last),
        .grant   (grant)
    );

    assign gsel  = grant[1];
    assign issue = (state == ST_IDLE) && (|grant) && mem_req_ready;
    assign done  = (state == ST_WAIT) && mem_req_ready;

    // ready is simply "slot empty", so it is registered by construction
    assign p0_ready = ~slot[0].pend;
    assign p1_ready = ~slot[1].pend;
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                slot[i]    <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!slot[i].pend && (rd_en[i] || wr_en[i])) begin
                    slot[i].pend  <= 1'b1;
                    slot[i].wr    <= wr_en[i];
                    slot[i].addr  <= addr_in[i];
                    slot[i].wdata <= wdat_in[i];
                end else if (done && (gidx == 1'(i))) begin
                    slot[i].pend <= 1'b0;
                    if (!slot[i].wr) begin
                        rdata_q[i] <= mem_rdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last         <= 1'b1;
            gidx         <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        gidx         <= gsel;
                        last         <= gsel;
                        mem_write_en <= slot[gsel].wr;
                        mem_read_en  <= ~slot[gsel].wr;
                        mem_addr     <= slot[gsel].addr;
                        mem_wdata    <= slot[gsel].wdata;
                        state        <= ST_ISSUE;
                    end
                end
                // controller has not yet dropped req_ready here
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (mem_req_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fram_arbiter.sv
// Self-checking bench for fram_arbiter with a behavioural FRAM controller.
// Expected mem commands are queued at stimulus time and popped on each strobe.
module tb_fram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_read_en, p0_write_en, p1_read_en, p1_write_en;
    logic [15:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_ready, p1_ready;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read_en, mem_write_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          port;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    cmd_t        exp_q[$];
    vec_t        vecs[9];
    int          checks = 0;
    int          errors = 0;
    int          strobes = 0;
    int          n_exp = 0;
    int          cnt = 0;
    logic [31:0] exp_rd[2];
    logic [31:0] mem   [0:65535];
    logic        mem_v [0:65535];

    fram_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p0_read_en    (p0_read_en),
        .p0_write_en   (p0_write_en),
        .p0_addr       (p0_addr),
        .p0_wdata      (p0_wdata),
        .p0_ready      (p0_ready),
        .p0_rdata      (p0_rdata),
        .p1_read_en    (p1_read_en),
        .p1_write_en   (p1_write_en),
        .p1_addr       (p1_addr),
        .p1_wdata      (p1_wdata),
        .p1_ready      (p1_ready),
        .p1_rdata      (p1_rdata),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_req_ready (mem_req_ready),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // controller model: req_ready drops after a strobe, returns 20 cycles later
    initial begin
        for (int a = 0; a < 65536; a++) mem_v[a] = 1'b0;
        forever begin
            @(posedge clk);
            if (mem_read_en || mem_write_en) begin
                mem_req_ready <= 1'b0;
                cnt <= 20;
                if (mem_write_en) begin
                    mem[mem_addr]   <= mem_wdata;
                    mem_v[mem_addr] <= 1'b1;
                end else begin
                    mem_rdata <= mem_v[mem_addr] ? mem[mem_addr]
                                                 : {16'hA5A5, mem_addr};
                end
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) mem_req_ready <= 1'b1;
            end
        end
    end

    initial begin
        cmd_t c;
        forever begin
            @(posedge clk);
            if (rst_n && (mem_read_en || mem_write_en)) begin
                strobes++;
                chk("one_strobe", {31'b0, mem_read_en & mem_write_en}, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got rd=%b wr=%b addr=%h expected none",
                             mem_read_en, mem_write_en, mem_addr);
                end else begin
                    c = exp_q.pop_front();
                    chk("cmd_wr", {31'b0, mem_write_en}, {31'b0, c.wr});
                    chk("cmd_addr", {16'b0, mem_addr}, {16'b0, c.addr});
                    if (c.wr) chk("cmd_wdata", mem_wdata, c.wdata);
                end
            end
        end
    end

    function automatic logic get_ready(int p);
        return (p == 0) ? p0_ready : p1_ready;
    endfunction

    function automatic logic [31:0] get_rdata(int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    task automatic drive(int p, logic rd, logic wr, logic [15:0] a, logic [31:0] d);
        if (p == 0) begin
            p0_read_en = rd; p0_write_en = wr; p0_addr = a; p0_wdata = d;
        end else begin
            p1_read_en = rd; p1_write_en = wr; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic clr();
        p0_read_en = 0; p0_write_en = 0;
        p1_read_en = 0; p1_write_en = 0;
    endtask

    task automatic push(logic wr, logic [15:0] a, logic [31:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = d;
        exp_q.push_back(c);
        n_exp++;
    endtask

    task automatic wait_ready(int p, bit lat, string name);
        int  rise = -1;
        bit  seen_low = 0;
        bit  ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (get_ready(p)) begin
                ok = 1;
                if (lat) chk({name, "_latency"}, i - rise, 1);
                break;
            end
            if (!mem_req_ready) seen_low = 1;
            else if (seen_low && rise < 0) rise = i;
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got ready=0 expected ready=1 within 200 cycles", name);
        end
    endtask

    task automatic run_vec(vec_t v, int k);
        push(v.wr, v.addr, v.wdata);
        drive(v.port, !v.wr, v.wr, v.addr, v.wdata);
        @(negedge clk);
        clr();
        chk($sformatf("v%0d_ready_drop", k), {31'b0, get_ready(v.port)}, 0);
        wait_ready(v.port, 1, $sformatf("v%0d", k));
        if (!v.wr) exp_rd[v.port] = v.exp_rdata;
        chk($sformatf("v%0d_rdata", k), get_rdata(v.port), exp_rd[v.port]);
        chk($sformatf("v%0d_rdata_other", k), get_rdata(1 - v.port), exp_rd[1 - v.port]);
    endtask

    task automatic tie(int first, logic [15:0] a0, logic [15:0] a1,
                       logic [31:0] e0, logic [31:0] e1);
        int second = 1 - first;
        if (first == 0) begin
            push(0, a0, 0); push(0, a1, 0);
        end else begin
            push(0, a1, 0); push(0, a0, 0);
        end
        drive(0, 1, 0, a0, 0);
        drive(1, 1, 0, a1, 0);
        @(negedge clk);
        clr();
        chk("tie_p0_busy", {31'b0, p0_ready}, 0);
        chk("tie_p1_busy", {31'b0, p1_ready}, 0);
        wait_ready(first, 0, "tie_first");
        chk("tie_second_pending", {31'b0, get_ready(second)}, 0);
        wait_ready(second, 0, "tie_second");
        exp_rd[0] = e0;
        exp_rd[1] = e1;
        chk("tie_p0_rdata", p0_rdata, e0);
        chk("tie_p1_rdata", p1_rdata, e1);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish expected finish within 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        bit drop;
        vecs[0] = '{0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1, 1'b1, 16'h0030, 32'h0BADF00D, 32'h0};
        vecs[3] = '{1, 1'b0, 16'h0030, 32'h0,        32'h0BADF00D};
        vecs[4] = '{0, 1'b0, 16'h00FF, 32'h0,        32'hA5A500FF};
        vecs[5] = '{0, 1'b1, 16'hFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[6] = '{1, 1'b0, 16'hFFFF, 32'h0,        32'hFFFFFFFF};
        vecs[7] = '{0, 1'b1, 16'h0000, 32'h00000000, 32'h0};
        vecs[8] = '{0, 1'b0, 16'h0000, 32'h0,        32'h00000000};
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        rst_n = 1'b0;
        clr();
        p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_p0_ready", {31'b0, p0_ready}, 1);
        chk("rst_p1_ready", {31'b0, p1_ready}, 1);
        chk("rst_mem_rd", {31'b0, mem_read_en}, 0);
        chk("rst_mem_wr", {31'b0, mem_write_en}, 0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);

        tie(0, 16'h0100, 16'h0200, 32'hA5A50100, 32'hA5A50200);

        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        // last grant was p0, so this tie must start with p1
        tie(1, 16'h0010, 16'h00FF, 32'hDEADBEEF, 32'hA5A500FF);

        push(0, 16'h0030, 0);
        push(1, 16'h0004, 32'h12345678);
        drive(0, 1, 0, 16'h0030, 0);
        @(negedge clk);
        clr();
        repeat (4) @(negedge clk);
        drive(1, 0, 1, 16'h0004, 32'h12345678);
        @(negedge clk);
        clr();
        chk("ovl_p1_busy", {31'b0, p1_ready}, 0);
        wait_ready(0, 0, "ovl_p0");
        exp_rd[0] = 32'h0BADF00D;
        chk("ovl_p0_rdata", p0_rdata, exp_rd[0]);
        @(negedge clk);
        chk("ovl_p1_immediate", {31'b0, mem_write_en}, 1);
        chk("ovl_p1_addr", {16'b0, mem_addr}, 32'h0004);
        wait_ready(1, 0, "ovl_p1");
        chk("ovl_p0_rdata_hold", p0_rdata, exp_rd[0]);
        chk("ovl_p1_rdata_hold", p1_rdata, exp_rd[1]);

        push(0, 16'h0004, 0);
        push(1, 16'h0020, 32'hCAFEF00D);
        drive(0, 1, 0, 16'h0004, 0);
        @(negedge clk);
        drive(0, 0, 1, 16'h0099, 32'h55555555);
        drive(1, 1, 1, 16'h0020, 32'hCAFEF00D);
        @(negedge clk);
        clr();
        wait_ready(0, 0, "ill_p0");
        exp_rd[0] = 32'h12345678;
        chk("ill_p0_rdata", p0_rdata, exp_rd[0]);
        wait_ready(1, 0, "ill_p1");
        chk("ill_p1_rdata_hold", p1_rdata, exp_rd[1]);
        run_vec('{1, 1'b0, 16'h0020, 32'h0, 32'hCAFEF00D}, 9);

        push(0, 16'h0010, 32'h77777777);
        drive(0, 1, 0, 16'h0010, 32'h77777777);
        @(negedge clk);
        clr();
        repeat (4) @(negedge clk);
        push(1, 16'h0030, 0);
        drive(1, 1, 0, 16'h0030, 0);
        @(negedge clk);
        clr();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_p0_ready", {31'b0, p0_ready}, 1);
        chk("mid_rst_p1_ready", {31'b0, p1_ready}, 1);
        chk("mid_rst_mem_rd", {31'b0, mem_read_en}, 0);
        chk("mid_rst_mem_wr", {31'b0, mem_write_en}, 0);
        chk("mid_rst_mem_addr", {16'b0, mem_addr}, 0);
        chk("mid_rst_mem_wdata", mem_wdata, 0);
        chk("mid_rst_p0_rdata", p0_rdata, 0);
        chk("mid_rst_p1_rdata", p1_rdata, 0);
        n_exp -= exp_q.size();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drop = 0;
        repeat (40) begin
            @(negedge clk);
            if (!p0_ready || !p1_ready) drop = 1;
        end
        chk("post_rst_idle", {31'b0, drop}, 0);
        chk("strobe_count", strobes, n_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fram_arbiter.md
FRAM_ARBITER -- requirements
Module: fram_arbiter

Interface
REQ-001 The block SHALL have input clk (1 bit), the rising-edge clock.
REQ-002 The block SHALL have input rst_n (1 bit), the reset: asynchronous, active-low.
REQ-003 For each port i in {0,1}, the block SHALL have inputs pi_read_en (1 bit) and pi_write_en (1 bit), each a single-cycle request strobe.
REQ-004 For each port i in {0,1}, the block SHALL have inputs pi_addr (16 bits, word address) and pi_wdata (32 bits, write data).
REQ-005 For each port i in {0,1}, the block SHALL have output pi_ready (1 bit): port idle, can accept a strobe.
REQ-006 For each port i in {0,1}, the block SHALL have output pi_rdata (32 bits): last read result for that port.
REQ-007 The block SHALL have outputs mem_read_en and mem_write_en (1 bit each): single-cycle strobes to the FRAM controller.
REQ-008 The block SHALL have outputs mem_addr (16 bits) and mem_wdata (32 bits): the granted port's command.
REQ-009 The block SHALL have inputs mem_req_ready (1 bit, controller idle) and mem_rdata (32 bits, controller read data).

Function
REQ-010 A port strobe SHALL be accepted only when pi_ready=1; a strobe while pi_ready=0 SHALL be ignored.
REQ-011 On acceptance, the block SHALL latch addr, wdata and the op into that port's pending slot and drive pi_ready=0 from the next cycle.
REQ-012 If read_en and write_en are asserted together, the write SHALL win.
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT, with all outputs registered.
REQ-014 IDLE: when any slot is pending and mem_req_ready=1, the block SHALL grant one port and assert exactly one of mem_read_en/mem_write_en for exactly one cycle, with mem_addr/mem_wdata from that slot, then go to ISSUE.
REQ-015 ISSUE: the block SHALL ignore mem_req_ready for one cycle and go to WAIT.
REQ-016 WAIT: on the first cycle mem_req_ready=1, the block SHALL copy mem_rdata into the granted port's pi_rdata (reads only), clear that slot, set that pi_ready=1 on the next edge, and return to IDLE.
REQ-017 Arbitration SHALL be round-robin: with both slots pending, grant the port not granted last; with one slot pending, grant it regardless of history.
REQ-018 After reset, the last-granted pointer SHALL be port 1, so port 0 wins the first tie.
REQ-019 A strobe on the non-granted port during ISSUE/WAIT SHALL be accepted into its slot and served next.
REQ-020 A port SHALL NOT issue a new strobe on the same edge its pi_ready rises; the earliest new strobe is the following cycle.
REQ-021 pi_rdata SHALL hold its value until the next completed read on that port, including across writes.
REQ-022 Arbiter overhead SHALL be 1 cycle from acceptance to the mem strobe (IDLE, mem_req_ready=1) and 1 cycle from mem_req_ready rising in WAIT to pi_ready=1.
REQ-023 If mem_req_ready=0 in IDLE, the grant SHALL be held off until it returns to 1.

Reset
REQ-024 rst_n low SHALL immediately force: state=IDLE, both slots empty, pi_ready=1, pi_rdata=0, mem_read_en=mem_write_en=0, mem_addr=0, mem_wdata=0, pointer=port 1.
REQ-025 Reset mid-transaction SHALL discard in-flight and pending requests, with no completion signalled.

Structure
REQ-026 Package fram_arb_pkg SHALL hold the state encoding, NUM_PORTS=2, ADDR_W=16 and DATA_W=32.
REQ-027 The round-robin grant logic SHALL be one sub-module, fram_rr_grant (pending[1:0] and last-grant in; grant one-hot out).

Verification (bench model: FRAM controller drops req_ready 1 cycle after a strobe, raises it N=20 cycles later)
REQ-028 Reset: after reset release -> both pi_ready=1, all mem outputs 0, both pi_rdata=0.
REQ-029 Single write then read: p0 writes 0x0010/0xDEADBEEF, then reads 0x0010 -> exactly one mem_write_en then one mem_read_en pulse; p0_rdata=0xDEADBEEF; p0_ready high 1 cycle after mem_req_ready rises.
REQ-030 Tie: p0 and p1 read on the same cycle after reset -> p0 is served first, then p1; the next tie goes to p1 first.
REQ-031 Overlap: p1 writes 0x0004 while p0's read is in WAIT -> p1 is issued immediately after p0 completes; p0_rdata unchanged by p1's write.
REQ-032 Illegal strobes: p0 strobes again while p0_ready=0, and p1 asserts read_en and write_en together -> the extra p0 strobe is ignored (one mem strobe only); p1 issues a write only.
REQ-033 Reset while in WAIT with p1 pending -> all outputs return to reset values immediately; no pi_ready completion and no further mem strobe after rst_n release.
